// File: rtl/controlador_recirculador.sv
// Control FSM for the four-lane recirculator: latches FIFO thresholds and drives selector_IDLE.
// Optional macro RECIRC_COUNT_EN adds a saturating counter of recirculated words.
module controlador_recirculador (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [3:0] umbral_alto_in,
  input  logic [3:0] umbral_bajo_in,
  input  logic [3:0] fifo_empty,
  input  logic [3:0] fifo_error,
  input  logic [3:0] valid_in,
  output logic       selector_IDLE,
  output logic       idle_out,
  output logic       active_out,
  output logic       error_out,
  output logic [2:0] estado,
  output logic [3:0] umbral_alto,
  output logic [3:0] umbral_bajo,
  output logic [7:0] recirc_count
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } estado_t;

  estado_t    r_estado;
  estado_t    w_estado_next;
  logic [3:0] r_alto;
  logic [3:0] r_bajo;

  always_comb begin
    w_estado_next = ST_ERROR;
    case (r_estado)
      ST_RESET: w_estado_next = ST_INIT;
      ST_INIT: begin
        if (init)                    w_estado_next = ST_INIT;
        else if (r_bajo >= r_alto)   w_estado_next = ST_ERROR;
        else if (fifo_empty == 4'hF) w_estado_next = ST_IDLE;
        else                         w_estado_next = ST_ACTIVE;
      end
      ST_IDLE, ST_ACTIVE: begin
        // A FIFO fault outranks a reinit request.
        if (|fifo_error)             w_estado_next = ST_ERROR;
        else if (init)               w_estado_next = ST_INIT;
        else if (fifo_empty == 4'hF) w_estado_next = ST_IDLE;
        else                         w_estado_next = ST_ACTIVE;
      end
      default: w_estado_next = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= ST_RESET;
      r_alto   <= 4'h0;
      r_bajo   <= 4'h0;
    end else begin
      r_estado <= w_estado_next;
      if (r_estado == ST_INIT && init) begin
        r_alto <= umbral_alto_in;
        r_bajo <= umbral_bajo_in;
      end
    end
  end

  assign estado        = r_estado;
  assign selector_IDLE = (r_estado != ST_ACTIVE);
  assign idle_out      = (r_estado == ST_IDLE);
  assign active_out    = (r_estado == ST_ACTIVE);
  assign error_out     = (r_estado == ST_ERROR);
  assign umbral_alto   = r_alto;
  assign umbral_bajo   = r_bajo;

`ifdef RECIRC_COUNT_EN
  logic [7:0] r_count;
  logic [2:0] w_pop;
  logic [8:0] w_sum;

  assign w_pop = {2'b00, valid_in[0]} + {2'b00, valid_in[1]}
               + {2'b00, valid_in[2]} + {2'b00, valid_in[3]};
  assign w_sum = {1'b0, r_count} + {6'b000000, w_pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'h00;
    end else if (w_estado_next == ST_INIT && r_estado != ST_INIT) begin
      r_count <= 8'h00;
    end else if (selector_IDLE) begin
      r_count <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  assign recirc_count = r_count;
`else
  logic w_unused_valid;
  assign w_unused_valid = ^valid_in;
  assign recirc_count   = 8'h00;
`endif

endmodule

// File: tb/tb_controlador_recirculador.sv
// Scoreboard bench for controlador_recirculador: directed scenarios then randomized traffic
// checked against a behavioural model of the state rules.
module tb_controlador_recirculador;

  localparam int S_RESET  = 0;
  localparam int S_INIT   = 1;
  localparam int S_IDLE   = 2;
  localparam int S_ACTIVE = 3;
  localparam int S_ERROR  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [3:0] umbral_alto_in = 4'h0;
  logic [3:0] umbral_bajo_in = 4'h0;
  logic [3:0] fifo_empty = 4'hF;
  logic [3:0] fifo_error = 4'h0;
  logic [3:0] valid_in = 4'h0;
  logic       selector_IDLE, idle_out, active_out, error_out;
  logic [2:0] estado;
  logic [3:0] umbral_alto, umbral_bajo;
  logic [7:0] recirc_count;

  controlador_recirculador dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto_in(umbral_alto_in), .umbral_bajo_in(umbral_bajo_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .valid_in(valid_in),
    .selector_IDLE(selector_IDLE), .idle_out(idle_out), .active_out(active_out),
    .error_out(error_out), .estado(estado), .umbral_alto(umbral_alto),
    .umbral_bajo(umbral_bajo), .recirc_count(recirc_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] est;
    logic       sel;
    logic       idl;
    logic       act;
    logic       err;
    logic [3:0] alto;
    logic [3:0] bajo;
    logic [7:0] cnt;
  } obs_t;

  obs_t q_exp[$];
  int   total = 0;
  int   bad = 0;

  // Behavioural model state
  int         m_st = S_RESET;
  logic [3:0] m_alto = 4'h0;
  logic [3:0] m_bajo = 4'h0;
  int         m_cnt = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.est  = 3'(m_st);
    o.sel  = (m_st != S_ACTIVE);
    o.idl  = (m_st == S_IDLE);
    o.act  = (m_st == S_ACTIVE);
    o.err  = (m_st == S_ERROR);
    o.alto = m_alto;
    o.bajo = m_bajo;
    o.cnt  = 8'(m_cnt);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {estado, selector_IDLE, idle_out, active_out, error_out,
         umbral_alto, umbral_bajo, recirc_count};
    return o;
  endfunction

  task automatic model_edge();
    int prev;
    int nxt;
    int words;
    if (reset) begin
      m_st = S_RESET; m_alto = 4'h0; m_bajo = 4'h0; m_cnt = 0;
      return;
    end
    prev = m_st;
    nxt  = S_ERROR;
    if (prev == S_RESET) nxt = S_INIT;
    else if (prev == S_INIT) begin
      if (init) nxt = S_INIT;
      else if (m_bajo >= m_alto) nxt = S_ERROR;
      else nxt = (fifo_empty == 4'hF) ? S_IDLE : S_ACTIVE;
    end else if (prev == S_IDLE || prev == S_ACTIVE) begin
      if (fifo_error != 4'h0) nxt = S_ERROR;
      else if (init) nxt = S_INIT;
      else nxt = (fifo_empty == 4'hF) ? S_IDLE : S_ACTIVE;
    end
    if (prev == S_INIT && init) begin
      m_alto = umbral_alto_in;
      m_bajo = umbral_bajo_in;
    end
`ifdef RECIRC_COUNT_EN
    words = 0;
    for (int k = 0; k < 4; k++) if (valid_in[k]) words++;
    if (nxt == S_INIT && prev != S_INIT) m_cnt = 0;
    else if (prev != S_ACTIVE) m_cnt = (m_cnt + words > 255) ? 255 : m_cnt + words;
`else
    words = 0;
    m_cnt = 0;
`endif
    m_st = nxt;
  endtask

  // One clock: drive inputs, let the edge happen, record the expected outcome.
  task automatic cyc(input logic rst, input logic ini, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] emp, input logic [3:0] er, input logic [3:0] v);
    reset = rst; init = ini; umbral_alto_in = a; umbral_bajo_in = b;
    fifo_empty = emp; fifo_error = er; valid_in = v;
    @(posedge clk);
    model_edge();
    q_exp.push_back(model_obs());
    @(negedge clk);
    #1;
  endtask

  task automatic check_direct(input string name, input obs_t want);
    obs_t got;
    got = dut_obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge.
  initial begin
    obs_t want;
    obs_t got;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        want = q_exp.pop_front();
        got  = dut_obs();
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL sb t=%0t got est=%0d sel=%0b i/a/e=%0b%0b%0b alto=%h bajo=%h cnt=%h want est=%0d sel=%0b i/a/e=%0b%0b%0b alto=%h bajo=%h cnt=%h",
                   $time, got.est, got.sel, got.idl, got.act, got.err, got.alto, got.bajo, got.cnt,
                   want.est, want.sel, want.idl, want.act, want.err, want.alto, want.bajo, want.cnt);
        end else begin
          $display("ok t=%0t est=%0d sel=%0b cnt=%h", $time, got.est, got.sel, got.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t rst_obs;
    obs_t tmp;
    rst_obs = '{est: 3'd0, sel: 1'b1, idl: 1'b0, act: 1'b0, err: 1'b0,
                alto: 4'h0, bajo: 4'h0, cnt: 8'h00};
    #1;
    check_direct("reset_initial", rst_obs);
    @(negedge clk); #1;
    cyc(1, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    cyc(1, 1, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);

    // Load C/3, land in IDLE, toggle ACTIVE/IDLE
    cyc(0, 1, 4'hC, 4'h3, 4'hF, 4'h0, 4'h0);
    cyc(0, 1, 4'hC, 4'h3, 4'hF, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    tmp = dut_obs();
    total++;
    if (tmp.alto !== 4'hC || tmp.est !== 3'd2) begin
      bad++;
      $display("FAIL idle_after_init: est=%0d alto=%h want est=2 alto=c", tmp.est, tmp.alto);
    end
    cyc(0, 0, 4'h0, 4'h0, 4'hE, 4'h0, 4'h1);
    cyc(0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h3);

    // Equal thresholds -> ERROR; init afterwards ignored
    cyc(0, 1, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0);
    cyc(0, 1, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0);
    cyc(0, 0, 4'h9, 4'h1, 4'hF, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'hA, 4'h2, 4'hF, 4'h0, 4'h7);

    // ACTIVE with simultaneous fault and init -> ERROR, then async reset
    cyc(1, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    cyc(0, 1, 4'hC, 4'h3, 4'h0, 4'h0, 4'h0);
    cyc(0, 1, 4'hC, 4'h3, 4'h0, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0);
    cyc(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b1;
    #1;
    check_direct("async_reset", rst_obs);
    cyc(1, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);

    // Counter saturation in IDLE
    cyc(0, 1, 4'hC, 4'h3, 4'hF, 4'h0, 4'h0);
    cyc(0, 1, 4'hC, 4'h3, 4'hF, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    for (int i = 0; i < 70; i++) cyc(0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
    total++;
`ifdef RECIRC_COUNT_EN
    if (recirc_count !== 8'hFF) begin
      bad++;
      $display("FAIL count_saturate: got=%h want=ff", recirc_count);
    end
`else
    if (recirc_count !== 8'h00) begin
      bad++;
      $display("FAIL count_tied: got=%h want=00", recirc_count);
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic       r_rst, r_ini;
      logic [3:0] r_emp, r_err;
      r_rst = ($urandom_range(0, 63) == 0);
      r_ini = ($urandom_range(0, 5) == 0);
      r_emp = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      r_err = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cyc(r_rst, r_ini, 4'($urandom), 4'($urandom), r_emp, r_err, 4'($urandom));
    end

    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: pending=%0d want=0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
